// File: rtl/forth_stack_mem_if.sv
// Decoder/ALU <-> stack store bus for forth_stack_mem.
// master = decoder/ALU side (issues ops), slave = the stack store.
interface forth_stack_mem_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 8
);
    logic          f_CLEAR;
    logic [1:0]    i_OP;
    logic [DW-1:0] i_DATA;
    logic [AW-1:0] i_PEEK_IDX;
    logic [DW-1:0] o_OP1;
    logic [DW-1:0] o_OP2;
    logic [DW-1:0] o_PEEK;
    logic [AW:0]   o_DEPTH;
    logic          o_EMPTY;
    logic          o_FULL;
    logic          o_OVF;
    logic          o_UNF;

    modport master (
        output f_CLEAR, i_OP, i_DATA, i_PEEK_IDX,
        input  o_OP1, o_OP2, o_PEEK, o_DEPTH, o_EMPTY, o_FULL, o_OVF, o_UNF
    );

    modport slave (
        input  f_CLEAR, i_OP, i_DATA, i_PEEK_IDX,
        output o_OP1, o_OP2, o_PEEK, o_DEPTH, o_EMPTY, o_FULL, o_OVF, o_UNF
    );
endinterface

// File: rtl/forth_stack_mem.sv
// Forth data/return stack store: one-cycle PUSH/POP/BINOP with registered
// top-of-stack, second element, depth and sticky error flags.
// Optional registered peek port (Forth PICK) built when FORTH_STACK_MEM_PEEK_EN
// is defined; otherwise o_PEEK is tied to 0 and i_PEEK_IDX is ignored.
module forth_stack_mem #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 8
) (
    input  logic               c_CLOCK,
    input  logic               c_RESET_N,
    forth_stack_mem_if.slave   bus
);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_PUSH  = 2'b01;
    localparam logic [1:0] OP_POP   = 2'b10;
    localparam logic [1:0] OP_BINOP = 2'b11;

    localparam logic [PW-1:0] DEPTH_MAX = PW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic [PW-1:0] depth_q;
    logic [PW-1:0] depth_d;
    logic          ovf_d;
    logic          unf_d;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] op1_d;
    logic [DW-1:0] op2_d;

    // Element idx of a stack of depth nd, with the pending write forwarded
    // so the registered outputs never show the pre-write RAM word.
    function automatic logic [DW-1:0] rd_elem(
        input logic [PW-1:0] nd,
        input logic [PW-1:0] idx,
        input logic          we,
        input logic [AW-1:0] wa,
        input logic [DW-1:0] wd
    );
        logic [PW-1:0] a;
        if (idx >= nd) begin
            return '0;
        end
        a = nd - idx - PW'(1);
        if (we && (a[AW-1:0] == wa)) begin
            return wd;
        end
        return mem[a[AW-1:0]];
    endfunction

    // Next stack state and post-op read values.
    always_comb begin
        depth_d = depth_q;
        ovf_d   = bus.o_OVF;
        unf_d   = bus.o_UNF;
        wr_en   = 1'b0;
        wr_addr = depth_q[AW-1:0];

        if (bus.f_CLEAR) begin
            depth_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            case (bus.i_OP)
                OP_PUSH: begin
                    if (depth_q == DEPTH_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = depth_q[AW-1:0];
                        depth_d = depth_q + PW'(1);
                    end
                end
                OP_POP: begin
                    if (depth_q == '0) begin
                        unf_d = 1'b1;
                    end else begin
                        depth_d = depth_q - PW'(1);
                    end
                end
                OP_BINOP: begin
                    if (depth_q < PW'(2)) begin
                        unf_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = AW'(depth_q - PW'(2));
                        depth_d = depth_q - PW'(1);
                    end
                end
                default: begin
                end
            endcase
        end

        op1_d = rd_elem(depth_d, PW'(0), wr_en, wr_addr, bus.i_DATA);
        op2_d = rd_elem(depth_d, PW'(1), wr_en, wr_addr, bus.i_DATA);
    end

    // Stack RAM write; contents are never reset, and a reset edge drops the op.
    always_ff @(posedge c_CLOCK) begin
        if (c_RESET_N && wr_en) begin
            mem[wr_addr] <= bus.i_DATA;
        end
    end

    // Pointer, flags and registered read outputs.
    always_ff @(posedge c_CLOCK) begin
        if (!c_RESET_N) begin
            depth_q     <= '0;
            bus.o_DEPTH <= '0;
            bus.o_OP1   <= '0;
            bus.o_OP2   <= '0;
            bus.o_EMPTY <= 1'b1;
            bus.o_FULL  <= 1'b0;
            bus.o_OVF   <= 1'b0;
            bus.o_UNF   <= 1'b0;
        end else begin
            depth_q     <= depth_d;
            bus.o_DEPTH <= depth_d;
            bus.o_OP1   <= op1_d;
            bus.o_OP2   <= op2_d;
            bus.o_EMPTY <= (depth_d == '0);
            bus.o_FULL  <= (depth_d == DEPTH_MAX);
            bus.o_OVF   <= ovf_d;
            bus.o_UNF   <= unf_d;
        end
    end

`ifdef FORTH_STACK_MEM_PEEK_EN
    logic [DW-1:0] peek_d;

    // Peek value of the post-op stack at the requested index.
    always_comb begin
        peek_d = rd_elem(depth_d, {1'b0, bus.i_PEEK_IDX}, wr_en, wr_addr, bus.i_DATA);
    end

    // Registered peek output.
    always_ff @(posedge c_CLOCK) begin
        if (!c_RESET_N) begin
            bus.o_PEEK <= '0;
        end else begin
            bus.o_PEEK <= peek_d;
        end
    end
`else
    logic unused_peek_idx;

    // Peek port not built.
    assign unused_peek_idx = ^bus.i_PEEK_IDX;
    assign bus.o_PEEK      = '0;
`endif

endmodule

// File: tb/tb_forth_stack_mem.sv
// Bench for forth_stack_mem: vector table on a 256-entry instance, plus
// hand-written full/overflow sequence on a 4-entry (AW=2) instance.
module tb_forth_stack_mem;
    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] PUSH  = 2'b01;
    localparam logic [1:0] POP   = 2'b10;
    localparam logic [1:0] BINOP = 2'b11;

`ifdef FORTH_STACK_MEM_PEEK_EN
    localparam bit PEEK_ON = 1'b1;
`else
    localparam bit PEEK_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    forth_stack_mem_if #(.DW(16), .AW(8)) bus8 ();
    forth_stack_mem_if #(.DW(16), .AW(2)) bus2 ();

    forth_stack_mem #(.DW(16), .AW(8)) u_dut8 (
        .c_CLOCK   (clk),
        .c_RESET_N (rst_n),
        .bus       (bus8.slave)
    );

    forth_stack_mem #(.DW(16), .AW(2)) u_dut2 (
        .c_CLOCK   (clk),
        .c_RESET_N (rst_n),
        .bus       (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        clr;
        logic [1:0]  op;
        logic [15:0] data;
        logic [7:0]  pidx;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [8:0]  depth;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
        logic [15:0] peek;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply8(input int n, input vec_t v);
        rst_n           = v.rst_n;
        bus8.f_CLEAR    = v.clr;
        bus8.i_OP       = v.op;
        bus8.i_DATA     = v.data;
        bus8.i_PEEK_IDX = v.pidx;
        bus2.f_CLEAR    = 1'b0;
        bus2.i_OP       = NOP;
        bus2.i_DATA     = '0;
        bus2.i_PEEK_IDX = '0;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d op1", n),   32'(bus8.o_OP1),   32'(v.op1));
        chk($sformatf("v%0d op2", n),   32'(bus8.o_OP2),   32'(v.op2));
        chk($sformatf("v%0d depth", n), 32'(bus8.o_DEPTH), 32'(v.depth));
        chk($sformatf("v%0d empty", n), 32'(bus8.o_EMPTY), 32'(v.empty));
        chk($sformatf("v%0d full", n),  32'(bus8.o_FULL),  32'(v.full));
        chk($sformatf("v%0d ovf", n),   32'(bus8.o_OVF),   32'(v.ovf));
        chk($sformatf("v%0d unf", n),   32'(bus8.o_UNF),   32'(v.unf));
        chk($sformatf("v%0d peek", n),  32'(bus8.o_PEEK),  PEEK_ON ? 32'(v.peek) : 32'd0);
    endtask

    task automatic step2(input logic clr, input logic [1:0] op, input logic [15:0] data,
                         input logic [1:0] pidx);
        rst_n           = 1'b1;
        bus8.f_CLEAR    = 1'b0;
        bus8.i_OP       = NOP;
        bus8.i_DATA     = '0;
        bus8.i_PEEK_IDX = '0;
        bus2.f_CLEAR    = clr;
        bus2.i_OP       = op;
        bus2.i_DATA     = data;
        bus2.i_PEEK_IDX = pidx;
        @(posedge clk);
        #1;
    endtask

    task automatic chk2(input string name, input logic [15:0] op1, input logic [15:0] op2,
                        input logic [2:0] depth, input logic full, input logic ovf);
        chk({name, " op1"},   32'(bus2.o_OP1),   32'(op1));
        chk({name, " op2"},   32'(bus2.o_OP2),   32'(op2));
        chk({name, " depth"}, 32'(bus2.o_DEPTH), 32'(depth));
        chk({name, " full"},  32'(bus2.o_FULL),  32'(full));
        chk({name, " ovf"},   32'(bus2.o_OVF),   32'(ovf));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;

        //          rst  clr op     data     pidx  op1      op2      dep  E  F  O  U  peek
        vecs[0]  = '{1'b0, 0, NOP,   16'h0000, 8'd0, 16'h0000, 16'h0000, 9'd0, 1, 0, 0, 0, 16'h0000};
        vecs[1]  = '{1'b1, 0, PUSH,  16'h0011, 8'd0, 16'h0011, 16'h0000, 9'd1, 0, 0, 0, 0, 16'h0011};
        vecs[2]  = '{1'b1, 0, PUSH,  16'h0022, 8'd1, 16'h0022, 16'h0011, 9'd2, 0, 0, 0, 0, 16'h0011};
        vecs[3]  = '{1'b1, 0, PUSH,  16'h0033, 8'd2, 16'h0033, 16'h0022, 9'd3, 0, 0, 0, 0, 16'h0011};
        vecs[4]  = '{1'b1, 0, BINOP, 16'h0055, 8'd1, 16'h0055, 16'h0011, 9'd2, 0, 0, 0, 0, 16'h0011};
        vecs[5]  = '{1'b1, 0, POP,   16'h0000, 8'd0, 16'h0011, 16'h0000, 9'd1, 0, 0, 0, 0, 16'h0011};
        vecs[6]  = '{1'b1, 0, POP,   16'h0000, 8'd0, 16'h0000, 16'h0000, 9'd0, 1, 0, 0, 0, 16'h0000};
        vecs[7]  = '{1'b1, 0, POP,   16'h0000, 8'd0, 16'h0000, 16'h0000, 9'd0, 1, 0, 0, 1, 16'h0000};
        vecs[8]  = '{1'b1, 0, PUSH,  16'h0001, 8'd0, 16'h0001, 16'h0000, 9'd1, 0, 0, 0, 1, 16'h0001};
        vecs[9]  = '{1'b1, 1, NOP,   16'h0000, 8'd0, 16'h0000, 16'h0000, 9'd0, 1, 0, 0, 0, 16'h0000};
        vecs[10] = '{1'b1, 0, BINOP, 16'h00EE, 8'd0, 16'h0000, 16'h0000, 9'd0, 1, 0, 0, 1, 16'h0000};
        vecs[11] = '{1'b1, 1, PUSH,  16'h0077, 8'd0, 16'h0000, 16'h0000, 9'd0, 1, 0, 0, 0, 16'h0000};
        vecs[12] = '{1'b1, 0, PUSH,  16'h000A, 8'd0, 16'h000A, 16'h0000, 9'd1, 0, 0, 0, 0, 16'h000A};
        vecs[13] = '{1'b1, 0, PUSH,  16'h000B, 8'd1, 16'h000B, 16'h000A, 9'd2, 0, 0, 0, 0, 16'h000A};
        vecs[14] = '{1'b1, 0, PUSH,  16'h000C, 8'd2, 16'h000C, 16'h000B, 9'd3, 0, 0, 0, 0, 16'h000A};
        vecs[15] = '{1'b1, 0, NOP,   16'h0000, 8'd3, 16'h000C, 16'h000B, 9'd3, 0, 0, 0, 0, 16'h0000};
        vecs[16] = '{1'b1, 0, NOP,   16'h0000, 8'd0, 16'h000C, 16'h000B, 9'd3, 0, 0, 0, 0, 16'h000C};
        vecs[17] = '{1'b1, 0, NOP,   16'h0000, 8'd1, 16'h000C, 16'h000B, 9'd3, 0, 0, 0, 0, 16'h000B};
        vecs[18] = '{1'b0, 0, PUSH,  16'h0099, 8'd0, 16'h0000, 16'h0000, 9'd0, 1, 0, 0, 0, 16'h0000};
        vecs[19] = '{1'b1, 0, PUSH,  16'h0005, 8'd0, 16'h0005, 16'h0000, 9'd1, 0, 0, 0, 0, 16'h0005};
        vecs[20] = '{1'b1, 0, BINOP, 16'h0007, 8'd0, 16'h0005, 16'h0000, 9'd1, 0, 0, 0, 1, 16'h0005};
        vecs[21] = '{1'b1, 0, NOP,   16'h0000, 8'd1, 16'h0005, 16'h0000, 9'd1, 0, 0, 0, 1, 16'h0000};

        for (int i = 0; i < 22; i++) begin
            apply8(i, vecs[i]);
        end

        // Small stack: fill, overflow, pop, then clear.
        step2(1'b1, NOP, 16'h0000, 2'd0);
        chk2("s2 clr", 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
        chk("s2 clr empty", 32'(bus2.o_EMPTY), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step2(1'b0, PUSH, 16'(k), 2'd3);
        end
        chk2("s2 full", 16'h0004, 16'h0003, 3'd4, 1'b1, 1'b0);
        chk("s2 full peek3", 32'(bus2.o_PEEK), PEEK_ON ? 32'h0001 : 32'd0);
        step2(1'b0, PUSH, 16'h0009, 2'd0);
        chk2("s2 ovf", 16'h0004, 16'h0003, 3'd4, 1'b1, 1'b1);
        chk("s2 ovf unf", 32'(bus2.o_UNF), 32'd0);
        step2(1'b0, POP, 16'h0000, 2'd2);
        chk2("s2 pop", 16'h0003, 16'h0002, 3'd3, 1'b0, 1'b1);
        chk("s2 pop peek2", 32'(bus2.o_PEEK), PEEK_ON ? 32'h0001 : 32'd0);
        step2(1'b0, BINOP, 16'h0008, 2'd0);
        chk2("s2 binop", 16'h0008, 16'h0001, 3'd2, 1'b0, 1'b1);
        step2(1'b1, PUSH, 16'h000F, 2'd0);
        chk2("s2 clr2", 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
